// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel duty,
// edge/center-aligned modes, shadow registers committed at period boundaries.
//
// dir_q      | meaning
// DIR_UP     | counter climbing (always the state in edge mode)
// DIR_DOWN   | center mode, counter descending back towards 0
module pwm_multi #(
    parameter int CHANNELS       = 4,
    parameter int COUNTER_WIDTH  = 16,
    parameter int PRESCALE_WIDTH = 8,
    parameter int ADDR_WIDTH     = $clog2(CHANNELS + 3)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [COUNTER_WIDTH-1:0] wr_data,
    output logic [CHANNELS-1:0]      pwm_out,
    output logic                     period_tick
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    localparam logic [ADDR_WIDTH-1:0]     A_PER  = ADDR_WIDTH'(CHANNELS);
    localparam logic [ADDR_WIDTH-1:0]     A_PRE  = ADDR_WIDTH'(CHANNELS + 1);
    localparam logic [ADDR_WIDTH-1:0]     A_MODE = ADDR_WIDTH'(CHANNELS + 2);
    localparam logic [COUNTER_WIDTH-1:0]  C_ONE  = COUNTER_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE  = PRESCALE_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0]  duty_sh_q  [CHANNELS];
    logic [COUNTER_WIDTH-1:0]  duty_sh_d  [CHANNELS];
    logic [COUNTER_WIDTH-1:0]  duty_act_q [CHANNELS];
    logic [COUNTER_WIDTH-1:0]  duty_act_d [CHANNELS];
    logic [COUNTER_WIDTH-1:0]  per_sh_q, per_sh_d, per_act_q, per_act_d;
    logic [PRESCALE_WIDTH-1:0] pre_sh_q, pre_sh_d, pre_act_q, pre_act_d;
    logic                      mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
    dir_e                      dir_q, dir_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      bnd_q, bnd_d;
    logic                      tick_q, tick_d;

    logic                      tick;
    logic                      boundary;
    logic [COUNTER_WIDTH-1:0]  p_max;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        per_sh_d   = per_sh_q;
        per_act_d  = per_act_q;
        pre_sh_d   = pre_sh_q;
        pre_act_d  = pre_act_q;
        mode_sh_d  = mode_sh_q;
        mode_act_d = mode_act_q;
        pcnt_d     = pcnt_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        boundary   = 1'b0;

        if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_addr == ADDR_WIDTH'(i)) duty_sh_d[i] = wr_data;
            end
            if (wr_addr == A_PER)  per_sh_d  = wr_data;
            if (wr_addr == A_PRE)  pre_sh_d  = wr_data[PRESCALE_WIDTH-1:0];
            if (wr_addr == A_MODE) mode_sh_d = wr_data[0];
        end

        // A stored period of 0 behaves as 1, so the top count is 0 in both cases.
        p_max = (per_act_q == '0) ? '0 : per_act_q - C_ONE;
        tick  = enable && (pcnt_q == pre_act_q);

        if (!enable) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + P_ONE;
            if (tick) begin
                if (p_max == '0) begin
                    boundary = 1'b1;
                end else if (!mode_act_q) begin
                    if (cnt_q == p_max) boundary = 1'b1;
                    else                cnt_d = cnt_q + C_ONE;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == p_max) dir_d = DIR_DOWN;
                    else                cnt_d = cnt_q + C_ONE;
                end else begin
                    if (cnt_q == '0) boundary = 1'b1;
                    else             cnt_d = cnt_q - C_ONE;
                end
                if (boundary) begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                end
            end
        end

        // Shadow values read here are pre-write, so a write landing on a
        // boundary waits for the following one.
        if (!enable || boundary) begin
            duty_act_d = duty_sh_q;
            per_act_d  = per_sh_q;
            pre_act_d  = pre_sh_q;
            mode_act_d = mode_sh_q;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = enable && (cnt_q < duty_act_q[i]);
        end

        // Delayed twice so the pulse lines up with pwm_out showing cnt = 0.
        bnd_d  = !enable || boundary;
        tick_d = enable && bnd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            per_sh_q   <= C_ONE;
            per_act_q  <= C_ONE;
            pre_sh_q   <= '0;
            pre_act_q  <= '0;
            mode_sh_q  <= 1'b0;
            mode_act_q <= 1'b0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            pwm_q      <= '0;
            bnd_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            per_sh_q   <= per_sh_d;
            per_act_q  <= per_act_d;
            pre_sh_q   <= pre_sh_d;
            pre_act_q  <= pre_act_d;
            mode_sh_q  <= mode_sh_d;
            mode_act_q <= mode_act_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            pwm_q      <= pwm_d;
            bnd_q      <= bnd_d;
            tick_q     <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule
